// File: rtl/apple_spawner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apple_spawner_if
// Brief    : Request / body-snapshot / apple-position bundle for the spawner.
//            master = snake controller side, slave = apple_spawner.
// Revision : 1.0 - initial release
// ============================================================================
interface apple_spawner_if #(
  parameter int MAX_LEN = 33
);
  logic                   eat_evt;
  logic [15:0]            rnd;
  logic [7:0]             snake_len;
  logic [MAX_LEN*10-1:0]  body_bus_x;
  logic [MAX_LEN*9-1:0]   body_bus_y;
  logic [9:0]             apple_x;
  logic [8:0]             apple_y;
  logic                   apple_valid;
  logic                   busy;
  logic                   fallback;

  modport master (
    output eat_evt, rnd, snake_len, body_bus_x, body_bus_y,
    input  apple_x, apple_y, apple_valid, busy, fallback
  );

  modport slave (
    input  eat_evt, rnd, snake_len, body_bus_x, body_bus_y,
    output apple_x, apple_y, apple_valid, busy, fallback
  );
endinterface
`default_nettype wire

// File: rtl/apple_spawner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apple_spawner
// Brief    : Places a new apple after each eat event. Random cells are drawn
//            from the LFSR word, rejected if on the border or under the snake
//            body (checked one segment per cycle against a snapshot). After
//            MAX_TRIES failed draws a linear sweep finds the first free cell.
// Revision : 1.0 - initial release
// ============================================================================
module apple_spawner #(
  parameter int CELL      = 10,
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int MAX_LEN   = 33,
  parameter int MAX_TRIES = 16,
  parameter int INIT_CX   = 40,
  parameter int INIT_CY   = 24
) (
  input wire             clk_pix,
  input wire             reset_n,
  apple_spawner_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [5:0]    c_cx_max    = 6'(GRID_W - 2);
  localparam logic [5:0]    c_cy_max    = 6'(GRID_H - 2);
  localparam logic [9:0]    c_cell_x    = 10'(CELL);
  localparam logic [8:0]    c_cell_y    = 9'(CELL);
  localparam logic [9:0]    c_init_x    = 10'(INIT_CX * CELL);
  localparam logic [8:0]    c_init_y    = 9'(INIT_CY * CELL);
  localparam logic [TW-1:0] c_max_tries = TW'(MAX_TRIES);
  localparam logic [LW-1:0] c_max_len   = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW   = 3'd1,
    S_SCAN   = 3'd2,
    S_SWEEP  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_cx, w_cx_nxt;
  logic [5:0]    r_cy, w_cy_nxt;
  logic [LW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_try, w_try_nxt;
  logic          r_sweep, w_sweep_nxt;
  logic          r_pending, w_pending_nxt;
  logic [9:0]    r_ax, w_ax_nxt;
  logic [8:0]    r_ay, w_ay_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_fallback, w_fallback_nxt;
  logic          w_accept;

  // Body snapshot taken when a search starts
  logic [9:0]    r_bx [MAX_LEN];
  logic [8:0]    r_by [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [LW-1:0] w_len_snap;
  logic [LW-1:0] w_last;

  // Candidate derived values
  logic [5:0]    w_rcx, w_rcy, w_rcx_cl, w_rcy_cl;
  logic          w_rnd_in;
  logic [5:0]    w_step_cx, w_step_cy;
  logic [9:0]    w_px;
  logic [8:0]    w_py;
  logic          w_hit;
  logic [TW-1:0] w_try_inc;

  logic          w_unused_rnd;
  assign w_unused_rnd = &{1'b0, bus.rnd[15:12]};

  assign w_rcx     = bus.rnd[5:0];
  assign w_rcy     = bus.rnd[11:6];
  assign w_rnd_in  = (w_rcx >= 6'd1) && (w_rcx <= c_cx_max) &&
                     (w_rcy >= 6'd1) && (w_rcy <= c_cy_max);
  assign w_px      = c_cell_x * {4'd0, r_cx};
  assign w_py      = c_cell_y * {3'd0, r_cy};
  assign w_hit     = (w_px == r_bx[r_idx]) && (w_py == r_by[r_idx]);
  assign w_try_inc = r_try + TW'(1);
  assign w_last    = r_len - LW'(1);

  // Clamp the random cell into the interior; this is also the sweep start point
  always_comb begin
    w_rcx_cl = w_rcx;
    w_rcy_cl = w_rcy;
    if (w_rcx < 6'd1)         w_rcx_cl = 6'd1;
    else if (w_rcx > c_cx_max) w_rcx_cl = c_cx_max;
    if (w_rcy < 6'd1)         w_rcy_cl = 6'd1;
    else if (w_rcy > c_cy_max) w_rcy_cl = c_cy_max;
  end

  // Next sweep cell in raster order, wrapping inside the interior
  always_comb begin
    w_step_cx = r_cx + 6'd1;
    w_step_cy = r_cy;
    if (r_cx >= c_cx_max) begin
      w_step_cx = 6'd1;
      w_step_cy = (r_cy >= c_cy_max) ? 6'd1 : r_cy + 6'd1;
    end
  end

  // Length 0 still checks the head; lengths beyond the bus are capped
  always_comb begin
    if (bus.snake_len == 8'd0)               w_len_snap = LW'(1);
    else if (bus.snake_len > 8'(MAX_LEN))    w_len_snap = c_max_len;
    else                                     w_len_snap = bus.snake_len[LW-1:0];
  end

  // Next-state and datapath update for the search FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_idx_nxt      = r_idx;
    w_try_nxt      = r_try;
    w_sweep_nxt    = r_sweep;
    w_pending_nxt  = r_pending;
    w_ax_nxt       = r_ax;
    w_ay_nxt       = r_ay;
    w_valid_nxt    = r_valid;
    w_busy_nxt     = r_busy;
    w_fallback_nxt = r_fallback;
    w_accept       = 1'b0;

    // An eat event during a search is remembered; repeats coalesce
    if (r_state != S_IDLE && bus.eat_evt) w_pending_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (bus.eat_evt || r_pending) begin
          w_accept      = 1'b1;
          w_state_nxt   = S_DRAW;
          w_try_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_valid_nxt   = 1'b0;
          w_pending_nxt = 1'b0;
          w_sweep_nxt   = 1'b0;
        end
      end
      S_DRAW: begin
        // Keep the clamped cell so a sweep can start from the last draw
        w_cx_nxt = w_rcx_cl;
        w_cy_nxt = w_rcy_cl;
        if (w_rnd_in) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN;
        end else begin
          w_try_nxt = w_try_inc;
          if (w_try_inc == c_max_tries) begin
            w_state_nxt    = S_SWEEP;
            w_sweep_nxt    = 1'b1;
            w_fallback_nxt = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          if (r_sweep) begin
            w_cx_nxt    = w_step_cx;
            w_cy_nxt    = w_step_cy;
            w_state_nxt = S_SWEEP;
          end else begin
            w_try_nxt = w_try_inc;
            if (w_try_inc == c_max_tries) begin
              w_state_nxt    = S_SWEEP;
              w_sweep_nxt    = 1'b1;
              w_fallback_nxt = 1'b1;
            end else begin
              w_state_nxt = S_DRAW;
            end
          end
        end else if (r_idx == w_last) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_idx_nxt = r_idx + LW'(1);
        end
      end
      S_SWEEP: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_SCAN;
      end
      S_COMMIT: begin
        w_ax_nxt    = w_px;
        w_ay_nxt    = w_py;
        w_valid_nxt = 1'b1;
        // Stay busy across back-to-back searches when a request is queued
        w_busy_nxt  = w_pending_nxt;
        w_sweep_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any search in flight
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_idx      <= '0;
      r_try      <= '0;
      r_sweep    <= 1'b0;
      r_pending  <= 1'b0;
      r_ax       <= c_init_x;
      r_ay       <= c_init_y;
      r_valid    <= 1'b1;
      r_busy     <= 1'b0;
      r_fallback <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_idx      <= w_idx_nxt;
      r_try      <= w_try_nxt;
      r_sweep    <= w_sweep_nxt;
      r_pending  <= w_pending_nxt;
      r_ax       <= w_ax_nxt;
      r_ay       <= w_ay_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_fallback <= w_fallback_nxt;
    end
  end

  // Capture body and length at search start so snake ticks mid-search are ignored
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      r_len <= LW'(1);
    end else if (w_accept) begin
      r_len <= w_len_snap;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_bx[i] <= bus.body_bus_x[i*10 +: 10];
        r_by[i] <= bus.body_bus_y[i*9 +: 9];
      end
    end
  end

  assign bus.apple_x     = r_ax;
  assign bus.apple_y     = r_ay;
  assign bus.apple_valid = r_valid;
  assign bus.busy        = r_busy;
  assign bus.fallback    = r_fallback;

endmodule
`default_nettype wire

// File: doc/apple_spawner.md
Name: apple_spawner

Overview:
- Upstream producer of the apple position.
- On each eat event it draws a random grid cell from the LFSR word and rejects cells on the border or under any snake segment.
- It publishes the accepted cell as pixel coordinates to the collision checker and renderer.
- It replaces fixed random placement with a sequential, body-aware search.

Parameters:
- CELL, 10, pixel size of one grid cell.
- GRID_W, 64, grid width in cells.
- GRID_H, 48, grid height in cells.
- MAX_LEN, 33, number of segment slots in the body buses; slot 0 is the head.
- MAX_TRIES, 16, random draws attempted before switching to linear sweep.
- INIT_CX, 40, apple cell column after reset.
- INIT_CY, 24, apple cell row after reset.

Ports:
- clk_pix  in  1  pixel clock (25 MHz); the only clock.
- reset_n  in  1  synchronous, active-low reset.
- eat_evt  in  1  single-cycle pulse: apple eaten, request a new one.
- rnd  in  16  free-running LFSR word.
- snake_len  in  8  current segment count, including the head.
- body_bus_x  in  MAX_LEN*10  segment x pixels; slot i occupies bits [i*10+9:i*10].
- body_bus_y  in  MAX_LEN*9  segment y pixels; slot i occupies bits [i*9+8:i*9].
- apple_x  out  10  apple pixel x, always a multiple of CELL.
- apple_y  out  9  apple pixel y, always a multiple of CELL.
- apple_valid  out  1  apple position is current; collision must be gated with it.
- busy  out  1  search in progress.
- fallback  out  1  sticky; set if any spawn needed the linear sweep.

Behaviour:
- Reset (reset_n=0 at a clk_pix edge):
  - state=IDLE.
  - apple_x=INIT_CX*CELL (400), apple_y=INIT_CY*CELL (240).
  - apple_valid=1, busy=0, fallback=0.
  - pending=0, try counter=0.
- Reset mid-search aborts the search immediately; there is no partial commit.
- States: IDLE, DRAW, SCAN, SWEEP, COMMIT.
- IDLE:
  - Entered on eat_evt or pending=1.
  - Snapshots snake_len (clamped to MAX_LEN), body_bus_x and body_bus_y.
  - Clears the try counter, goes to DRAW.
  - On the next cycle: busy=1, apple_valid=0. apple_x/apple_y hold the old value.
- DRAW (1 cycle):
  - cx=rnd[5:0], cy=rnd[11:6].
  - The cell is in range iff 1<=cx<=GRID_W-2 and 1<=cy<=GRID_H-2.
  - In range: seg index=0, go to SCAN.
  - Out of range: try+1; go to DRAW again, or to SWEEP if try reaches MAX_TRIES.
- SCAN:
  - Checks one segment per cycle: compare cx*CELL with slot[idx] x and cy*CELL with slot[idx] y.
  - Match: reject, try+1, then DRAW, or SWEEP if try reaches MAX_TRIES.
  - idx==len-1 with no match: go to COMMIT.
  - len==0 is treated as len=1 (the head is always checked).
- SWEEP:
  - Starts from the last candidate, clamped into range.
  - Steps cx+1 within the range; past GRID_W-2 it wraps to cx=1, cy+1; past GRID_H-2 it wraps to cy=1.
  - Each candidate gets a full SCAN pass, using the same compare logic.
  - The first free cell goes to COMMIT.
  - Sets fallback=1.
  - Always terminates, because MAX_LEN is much smaller than the interior cell count.
- COMMIT (1 cycle):
  - apple_x<=cx*CELL, apple_y<=cy*CELL, apple_valid<=1, busy<=0.
  - Returns to IDLE.
- Latency: the best case from eat_evt to apple_valid=1 is 1 (accept) + 1 (DRAW) + len (SCAN) + 1 (COMMIT) = len+3 cycles.
- eat_evt arriving while busy sets pending=1.
  - Only one pending request is held; further events coalesce into it.
  - The pending request is serviced straight from COMMIT→IDLE→new search.
- eat_evt arriving in the same cycle as reset is ignored.
- Arithmetic:
  - cx*CELL is computed as a 10-bit product and cy*CELL as a 9-bit product.
  - No truncation occurs within the default parameters.
- The live bus may change during a search (a snake tick); only the snapshot is used.

Test Plan:
- Reset only -> apple_x=400, apple_y=240, apple_valid=1, busy=0, fallback=0.
- eat_evt with rnd=0x0305 (cx=5, cy=12), snake_len=2 at (300,240)/(290,240) -> busy for 4 cycles, apple_valid=1 at t+5, apple=(50,120).
- rnd held at 0x0000 (cx=0, out of range) for the whole search -> 16 draws, then SWEEP from (1,1), apple=(10,10), fallback=1.
- rnd fixed to cell (5,12) with snake head at (50,120) -> every draw rejected, SWEEP commits (6,12), apple=(60,120).
- Second eat_evt 2 cycles after the first -> pending served; two COMMITs, busy high continuously between them, final apple from the second draw.
- reset_n low during SCAN -> next cycle apple=(400,240), apple_valid=1, busy=0, pending cleared.
